// File: rtl/window_3x3_gen_if.sv
// Stream bundle between the pixel source, window_3x3_gen and the 3x3 median stage.
// Carries the raster-order input beat (valid/sof/pixel) and the registered 9-tap window output.
// master drives the pixel stream and receives the window; slave is the generator side.
interface window_3x3_gen_if #(
  parameter int BIT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_sof;
  logic [BIT_WIDTH-1:0] in_pixel;
  logic                 out_valid;
  logic                 out_border;
  logic [BIT_WIDTH-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, out_border, p0, p1, p2, p3, p4, p5, p6, p7, p8
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, out_border, p0, p1, p2, p3, p4, p5, p6, p7, p8
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Purpose : streaming 3x3 neighbourhood generator; two line buffers + 3x3 window per accepted pixel.
// Latency : beat accepted at edge t updates the window; registered taps/out_valid appear after edge t+1.
// Backpr. : none; every in_valid beat is accepted and every out_valid beat must be consumed.
// Ports   : clk, rst (sync, active-high); s = slave side of window_3x3_gen_if
//           (in_valid/in_sof/in_pixel in; out_valid/out_border/p0..p8 out, p0 top-left, p8 newest).
// Config  : define BORDER_ZERO_EN to force p0..p8 to 0 on border windows.
module window_3x3_gen #(
  parameter int BIT_WIDTH  = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  window_3x3_gen_if.slave       s
);
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

`ifdef BORDER_ZERO_EN
  localparam bit ZERO_BORDER = 1'b1;
`else
  localparam bit ZERO_BORDER = 1'b0;
`endif

  logic [XW-1:0] x, x_eff, x_nxt;
  logic [YW-1:0] y, y_eff, y_nxt;
  logic          beat;
  logic          beat_border;
  logic [BIT_WIDTH-1:0] rd0, rd1;

  logic [BIT_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [BIT_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [BIT_WIDTH-1:0] win [3][3];   // [row][col], row 0 = two lines up, col 2 = newest

  logic                 vld_q;
  logic                 brd_q;
  logic                 out_valid_q;
  logic                 out_border_q;
  logic [BIT_WIDTH-1:0] tap_q [9];
  logic                 zero_taps;

  assign beat = s.in_valid && !rst;

  // A start-of-frame beat is placed at (0,0) whatever the counters say.
  always_comb begin
    x_eff = x;
    y_eff = y;
    if (s.in_sof) begin
      x_eff = '0;
      y_eff = '0;
    end
    x_nxt = x_eff + XW'(1);
    y_nxt = y_eff;
    if (x_eff == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y_eff == Y_LAST) ? '0 : y_eff + YW'(1);
    end
    rd0         = lb0[x_eff];
    rd1         = lb1[x_eff];
    beat_border = (x_eff < XW'(2)) || (y_eff < YW'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      vld_q <= 1'b0;
      brd_q <= 1'b0;
    end else begin
      vld_q <= s.in_valid;
      if (s.in_valid) begin
        x     <= x_nxt;
        y     <= y_nxt;
        brd_q <= beat_border;
      end
    end
  end

  // Line buffers and window shift register: contents need no reset.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb1[x_eff] <= rd0;
      lb0[x_eff] <= s.in_pixel;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= rd1;
      win[1][2] <= rd0;
      win[2][2] <= s.in_pixel;
    end
  end

  assign zero_taps = ZERO_BORDER && brd_q;

  // Output register: taps and border only move when a new window is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_border_q <= 1'b0;
      for (int i = 0; i < 9; i++) tap_q[i] <= '0;
    end else begin
      out_valid_q <= vld_q;
      if (vld_q) begin
        out_border_q <= brd_q;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            tap_q[r*3+c] <= zero_taps ? '0 : win[r][c];
          end
        end
      end
    end
  end

  assign s.out_valid  = out_valid_q;
  assign s.out_border = out_border_q;
  assign s.p0 = tap_q[0];
  assign s.p1 = tap_q[1];
  assign s.p2 = tap_q[2];
  assign s.p3 = tap_q[3];
  assign s.p4 = tap_q[4];
  assign s.p5 = tap_q[5];
  assign s.p6 = tap_q[6];
  assign s.p7 = tap_q[7];
  assign s.p8 = tap_q[8];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on an 8x6 frame with pixel value y*8+x.
// Expected windows are queued per driven beat and matched against each out_valid beat.
// out_valid is also checked every cycle against a delayed copy of the driven in_valid.
module tb_window_3x3_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.BIT_WIDTH(BW)) ifc ();

  window_3x3_gen #(
    .BIT_WIDTH (BW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s  (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int               x;
    int               y;
    bit               border;
    logic [7:0]       pixel;
    logic [8:0][7:0]  taps;
  } exp_t;

  exp_t sb[$];
  int   tx = 0;
  int   ty = 0;

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'(y * W + x);
  endfunction

  task automatic drive_beat(input bit sof);
    exp_t e;
    if (sof) begin
      tx = 0;
      ty = 0;
    end
    e.x      = tx;
    e.y      = ty;
    e.border = (tx < 2) || (ty < 2);
    e.pixel  = pix(tx, ty);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e.taps[r*3+c] = e.border ? 8'h00 : pix(tx - 2 + c, ty - 2 + r);
    sb.push_back(e);
    ifc.in_valid = 1'b1;
    ifc.in_sof   = sof;
    ifc.in_pixel = e.pixel;
    if (tx == W - 1) begin
      tx = 0;
      ty = (ty == H - 1) ? 0 : ty + 1;
    end else begin
      tx = tx + 1;
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
    ifc.in_pixel = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_cleared(input string where);
    logic [8:0][7:0] got;
    got = {ifc.p8, ifc.p7, ifc.p6, ifc.p5, ifc.p4, ifc.p3, ifc.p2, ifc.p1, ifc.p0};
    chk({where, "_out_valid"}, ifc.out_valid, 0);
    chk({where, "_out_border"}, ifc.out_border, 0);
    chk({where, "_taps"}, got, 0);
  endtask

  // Expected out_valid: in_valid delayed by two edges, cleared by reset.
  bit v1 = 1'b0;
  bit v2 = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      v1 <= ifc.in_valid;
    end
  end

  always @(negedge clk) begin
    exp_t            e;
    logic [8:0][7:0] got;
    if (!rst) chk("out_valid", ifc.out_valid, v2);
    if (ifc.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e   = sb.pop_front();
        got = {ifc.p8, ifc.p7, ifc.p6, ifc.p5, ifc.p4, ifc.p3, ifc.p2, ifc.p1, ifc.p0};
        chk($sformatf("border@(%0d,%0d)", e.x, e.y), ifc.out_border, e.border);
`ifdef BORDER_ZERO_EN
        for (int k = 0; k < 9; k++)
          chk($sformatf("p%0d@(%0d,%0d)", k, e.x, e.y), got[k], e.taps[k]);
`else
        if (!e.border) begin
          for (int k = 0; k < 9; k++)
            chk($sformatf("p%0d@(%0d,%0d)", k, e.x, e.y), got[k], e.taps[k]);
        end else begin
          chk($sformatf("p8raw@(%0d,%0d)", e.x, e.y), got[8], e.pixel);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
    ifc.in_pixel = '0;
    idle(2);
    check_cleared("reset");
    rst = 1'b0;
    idle(1);

    // Frame A: continuous.
    for (int i = 0; i < W * H; i++) drive_beat(i == 0);
    // Frame B: in_valid every other cycle, sof on first pixel.
    for (int i = 0; i < W * H; i++) begin
      drive_beat(i == 0);
      idle(1);
    end
    // Frame C: sof again when the counters sit at (5,3).
    for (int i = 0; i < 29; i++) drive_beat(i == 0);
    drive_beat(1'b1);
    for (int i = 0; i < 20; i++) drive_beat(1'b0);

    // Mid-line reset; first beat afterwards lands at (0,0) without sof.
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_cleared("midreset");
    tx = 0;
    ty = 0;
    for (int i = 0; i < W * H; i++) drive_beat(1'b0);
    // Back-to-back frame with sof.
    for (int i = 0; i < W * H; i++) drive_beat(i == 0);

    idle(4);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
